// File: rtl/flag_alu_if.sv
// Request/response bundle for flag_alu: operands in, result, handshake
// status and flag/enable outputs toward the status-register stage.
interface flag_alu_if;
    logic        start;
    logic [3:0]  op;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] result;
    logic        valid;
    logic        busy;
    logic        C_out;
    logic        L_out;
    logic        F_out;
    logic        Z_out;
    logic        N_out;
    logic        cmp_f_en;
    logic        of_f_en;
    logic        z_f_en;

    modport master (
        output start, op, a, b,
        input  result, valid, busy,
        input  C_out, L_out, F_out, Z_out, N_out,
        input  cmp_f_en, of_f_en, z_f_en
    );

    modport slave (
        input  start, op, a, b,
        output result, valid, busy,
        output C_out, L_out, F_out, Z_out, N_out,
        output cmp_f_en, of_f_en, z_f_en
    );
endinterface

// File: rtl/flag_alu.sv
// Multi-cycle 16-bit ALU with status flags and flag write enables.
// Define FLAG_ALU_MUL_EN to build the iterative shift-add multiplier.
module flag_alu (
    input  logic       clk,
    input  logic       reset,
    flag_alu_if.slave  bus
);
    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_CMP = 4'd2;
    localparam logic [3:0] OP_AND = 4'd3;
    localparam logic [3:0] OP_OR  = 4'd4;
    localparam logic [3:0] OP_XOR = 4'd5;
    localparam logic [3:0] OP_LSH = 4'd6;
`ifdef FLAG_ALU_MUL_EN
    localparam logic [3:0] OP_MUL = 4'd7;
    typedef enum logic [1:0] {IDLE, SHIFT, DONE, MUL} state_t;
`else
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
`endif

    state_t      state_q, state_d;
    logic [15:0] res_q, res_d;
    logic        c_q, c_d, l_q, l_d, f_q, f_d, z_q, z_d, n_q, n_d;
    logic [2:0]  en_q, en_d;
    logic [15:0] sh_q, sh_d;
    logic [4:0]  cnt_q, cnt_d;
    logic        left_q, left_d;

    logic [16:0] add_w, sub_w;
    logic        add_ovf, sub_ovf, slt;
    logic [4:0]  mag;
    logic [15:0] sh_nx;

    assign add_w   = {1'b0, bus.a} + {1'b0, bus.b};
    assign sub_w   = {1'b0, bus.a} - {1'b0, bus.b};
    assign add_ovf = (bus.a[15] == bus.b[15]) && (add_w[15] != bus.a[15]);
    assign sub_ovf = (bus.a[15] != bus.b[15]) && (sub_w[15] != bus.a[15]);
    assign slt     = $signed(bus.a) < $signed(bus.b);
    // Shift amount is 5-bit two's complement; -16 gives magnitude 16.
    assign mag     = bus.b[4] ? (~bus.b[4:0] + 5'd1) : bus.b[4:0];
    assign sh_nx   = left_q ? {sh_q[14:0], 1'b0} : {1'b0, sh_q[15:1]};

`ifdef FLAG_ALU_MUL_EN
    logic [31:0] acc_q, acc_d, mc_q, mc_d, acc_nx;
    logic [15:0] mp_q, mp_d;
    assign acc_nx = mp_q[0] ? acc_q + mc_q : acc_q;
`endif

    always_comb begin
        state_d = state_q;
        res_d   = res_q;
        c_d     = c_q;
        l_d     = l_q;
        f_d     = f_q;
        z_d     = z_q;
        n_d     = n_q;
        en_d    = 3'b000;
        sh_d    = sh_q;
        cnt_d   = cnt_q;
        left_d  = left_q;
`ifdef FLAG_ALU_MUL_EN
        acc_d   = acc_q;
        mc_d    = mc_q;
        mp_d    = mp_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d = DONE;
                    case (bus.op)
                        OP_ADD: begin
                            res_d = add_w[15:0];
                            c_d   = add_w[16];
                            f_d   = add_ovf;
                            z_d   = (add_w[15:0] == 16'd0);
                            en_d  = 3'b011;
                        end
                        OP_SUB: begin
                            res_d = sub_w[15:0];
                            c_d   = sub_w[16];
                            f_d   = sub_ovf;
                            z_d   = (sub_w[15:0] == 16'd0);
                            en_d  = 3'b011;
                        end
                        OP_CMP: begin
                            l_d  = sub_w[16];
                            n_d  = slt;
                            z_d  = (bus.a == bus.b);
                            en_d = 3'b101;
                        end
                        OP_AND: begin
                            res_d = bus.a & bus.b;
                            z_d   = ((bus.a & bus.b) == 16'd0);
                            en_d  = 3'b001;
                        end
                        OP_OR: begin
                            res_d = bus.a | bus.b;
                            z_d   = ((bus.a | bus.b) == 16'd0);
                            en_d  = 3'b001;
                        end
                        OP_XOR: begin
                            res_d = bus.a ^ bus.b;
                            z_d   = ((bus.a ^ bus.b) == 16'd0);
                            en_d  = 3'b001;
                        end
                        OP_LSH: begin
                            if (mag != 5'd0) begin
                                state_d = SHIFT;
                                sh_d    = bus.a;
                                cnt_d   = mag;
                                left_d  = ~bus.b[4];
                            end else begin
                                res_d = bus.a;
                            end
                        end
`ifdef FLAG_ALU_MUL_EN
                        OP_MUL: begin
                            state_d = MUL;
                            acc_d   = 32'd0;
                            mc_d    = {16'd0, bus.a};
                            mp_d    = bus.b;
                            cnt_d   = 5'd16;
                        end
`endif
                        default: res_d = 16'd0;
                    endcase
                end
            end
            SHIFT: begin
                sh_d  = sh_nx;
                cnt_d = cnt_q - 5'd1;
                if (cnt_q == 5'd1) begin
                    state_d = DONE;
                    res_d   = sh_nx;
                end
            end
`ifdef FLAG_ALU_MUL_EN
            MUL: begin
                acc_d = acc_nx;
                mc_d  = {mc_q[30:0], 1'b0};
                mp_d  = {1'b0, mp_q[15:1]};
                cnt_d = cnt_q - 5'd1;
                if (cnt_q == 5'd1) begin
                    state_d = DONE;
                    res_d   = acc_nx[15:0];
                    f_d     = (acc_nx[31:16] != 16'd0);
                    c_d     = (acc_nx[31:16] != 16'd0);
                    z_d     = (acc_nx[15:0] == 16'd0);
                    en_d    = 3'b011;
                end
            end
`endif
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            res_q   <= 16'd0;
            c_q     <= 1'b0;
            l_q     <= 1'b0;
            f_q     <= 1'b0;
            z_q     <= 1'b0;
            n_q     <= 1'b0;
            en_q    <= 3'b000;
            sh_q    <= 16'd0;
            cnt_q   <= 5'd0;
            left_q  <= 1'b0;
`ifdef FLAG_ALU_MUL_EN
            acc_q   <= 32'd0;
            mc_q    <= 32'd0;
            mp_q    <= 16'd0;
`endif
        end else begin
            state_q <= state_d;
            res_q   <= res_d;
            c_q     <= c_d;
            l_q     <= l_d;
            f_q     <= f_d;
            z_q     <= z_d;
            n_q     <= n_d;
            en_q    <= en_d;
            sh_q    <= sh_d;
            cnt_q   <= cnt_d;
            left_q  <= left_d;
`ifdef FLAG_ALU_MUL_EN
            acc_q   <= acc_d;
            mc_q    <= mc_d;
            mp_q    <= mp_d;
`endif
        end
    end

    assign bus.result   = res_q;
    assign bus.valid    = (state_q == DONE);
    assign bus.busy     = (state_q != IDLE);
    assign bus.C_out    = c_q;
    assign bus.L_out    = l_q;
    assign bus.F_out    = f_q;
    assign bus.Z_out    = z_q;
    assign bus.N_out    = n_q;
    assign bus.cmp_f_en = en_q[2];
    assign bus.of_f_en  = en_q[1];
    assign bus.z_f_en   = en_q[0];
endmodule
